// File: rtl/bcd_count_ctrl_if.sv
// Command, digit and status bundle between the run/lap controller and its environment.
// Signal prefixes are from the controller's point of view (i_ into it, o_ out of it).
interface bcd_count_ctrl_if;
   logic       i_start_stop;
   logic       i_clear;
   logic       i_lap;
   logic [3:0] i_q0;
   logic [3:0] i_q1;
   logic [3:0] i_q2;
   logic       i_tc;
   logic       o_inc;
   logic       o_cnt_clr;
   logic [3:0] o_disp0;
   logic [3:0] o_disp1;
   logic [3:0] o_disp2;
   logic       o_running;
   logic       o_lap_active;
   logic       o_done;
   logic       o_overflow;

   modport master (
      input  i_start_stop, i_clear, i_lap, i_q0, i_q1, i_q2, i_tc,
      output o_inc, o_cnt_clr, o_disp0, o_disp1, o_disp2,
             o_running, o_lap_active, o_done, o_overflow
   );

   modport slave (
      output i_start_stop, i_clear, i_lap, i_q0, i_q1, i_q2, i_tc,
      input  o_inc, o_cnt_clr, o_disp0, o_disp1, o_disp2,
             o_running, o_lap_active, o_done, o_overflow
   );
endinterface

// File: rtl/bcd_count_ctrl.sv
// Run/pause/clear/lap controller for a 3-digit BCD counter; wrap-at-999 via BCD_COUNT_CTRL_WRAP_EN.
// Latency: every output registered; first inc TICK_DIV cycles after start, then every TICK_DIV.
// Backpressure: none; commands are single-cycle pulses, same-cycle priority clear > start_stop > lap.
module bcd_count_ctrl #(
   parameter int TICK_DIV = 100000
) (
   input logic             i_clk,
   input logic             i_reset,
   bcd_count_ctrl_if.master ctrl_if
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t          r_state;
   logic [PW-1:0]   r_presc;
   logic            r_inc;
   logic            r_cnt_clr;
   logic            r_running;
   logic            r_done;
   logic            r_lap_active;
   logic            r_overflow;
   logic [3:0]      r_disp0;
   logic [3:0]      r_disp1;
   logic [3:0]      r_disp2;

   state_t          w_state_n;
   logic [PW-1:0]   w_presc_cur;
   logic [PW-1:0]   w_presc_n;
   logic            w_slot;
   logic            w_tick;
   logic            w_inc_n;
   logic            w_cnt_clr_n;
   logic            w_lap_n;
   logic            w_ovf_n;

`ifndef BCD_COUNT_CTRL_WRAP_EN
   logic            w_at_max;
   logic            w_unused_tc;

   assign w_at_max    = (ctrl_if.i_q0 == 4'd9) && (ctrl_if.i_q1 == 4'd9) && (ctrl_if.i_q2 == 4'd9);
   assign w_unused_tc = ctrl_if.i_tc;
`endif

   // IDLE always holds a zero prescaler, but the start cycle itself is counted as slot 0.
   assign w_presc_cur = (r_state == ST_IDLE) ? '0 : r_presc;

   always_comb begin
      w_state_n   = r_state;
      w_presc_n   = r_presc;
      w_slot      = 1'b0;
      w_tick      = 1'b0;
      w_inc_n     = 1'b0;
      w_cnt_clr_n = 1'b0;
      w_lap_n     = r_lap_active;
      w_ovf_n     = r_overflow;

      if (ctrl_if.i_clear) begin
         w_state_n   = ST_IDLE;
         w_presc_n   = '0;
         w_cnt_clr_n = 1'b1;
         w_lap_n     = 1'b0;
         w_ovf_n     = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (ctrl_if.i_start_stop) begin
                  w_state_n = ST_RUN;
                  w_slot    = 1'b1;
               end
            end
            ST_RUN: begin
               if (ctrl_if.i_start_stop) begin
                  w_state_n = ST_PAUSE;
               end else begin
                  w_slot = 1'b1;
                  if (ctrl_if.i_lap) w_lap_n = ~r_lap_active;
               end
            end
            ST_PAUSE: begin
               if (ctrl_if.i_start_stop) begin
                  w_state_n = ST_RUN;
                  w_slot    = 1'b1;
               end else if (ctrl_if.i_lap) begin
                  w_lap_n = ~r_lap_active;
               end
            end
            ST_DONE: begin
               w_state_n = ST_DONE;
            end
            default: begin
               w_state_n = ST_IDLE;
            end
         endcase

         if (w_slot) begin
            if (w_presc_cur == P_LAST) begin
               w_presc_n = '0;
               w_tick    = 1'b1;
            end else begin
               w_presc_n = w_presc_cur + 1'b1;
            end
         end

`ifdef BCD_COUNT_CTRL_WRAP_EN
         if (w_tick) w_inc_n = 1'b1;
         if (ctrl_if.i_tc) w_ovf_n = 1'b1;
`else
         // At 999 the tick is swallowed and the run ends instead of wrapping.
         if (w_tick) begin
            if (w_at_max) begin
               w_state_n = ST_DONE;
            end else begin
               w_inc_n = 1'b1;
            end
         end
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_presc      <= '0;
         r_inc        <= 1'b0;
         r_cnt_clr    <= 1'b1;
         r_running    <= 1'b0;
         r_done       <= 1'b0;
         r_lap_active <= 1'b0;
         r_overflow   <= 1'b0;
         r_disp0      <= 4'd0;
         r_disp1      <= 4'd0;
         r_disp2      <= 4'd0;
      end else begin
         r_state      <= w_state_n;
         r_presc      <= w_presc_n;
         r_inc        <= w_inc_n;
         r_cnt_clr    <= w_cnt_clr_n;
         r_running    <= (w_state_n == ST_RUN);
         r_done       <= (w_state_n == ST_DONE);
         r_lap_active <= w_lap_n;
         r_overflow   <= w_ovf_n;
         // The cycle lap rises still sees the old flag low, so it captures the live digits.
         if (!r_lap_active) begin
            r_disp0 <= ctrl_if.i_q0;
            r_disp1 <= ctrl_if.i_q1;
            r_disp2 <= ctrl_if.i_q2;
         end
      end
   end

   assign ctrl_if.o_inc        = r_inc;
   assign ctrl_if.o_cnt_clr    = r_cnt_clr;
   assign ctrl_if.o_running    = r_running;
   assign ctrl_if.o_done       = r_done;
   assign ctrl_if.o_lap_active = r_lap_active;
   assign ctrl_if.o_overflow   = r_overflow;
   assign ctrl_if.o_disp0      = r_disp0;
   assign ctrl_if.o_disp1      = r_disp1;
   assign ctrl_if.o_disp2      = r_disp2;

endmodule
